id_ex_stage: RTL and testbench

- ID/EX pipeline register of the miniRV 5-stage pipeline.
- Consumes the ID-stage hazard/forwarding results and selects operand data.
- Inserts a bubble on load-use and flushes on a taken branch/jump resolved in EX.
- Holds its contents on a global pipeline freeze.
- Also drives the PC / IF-ID stall requests.

---
 rtl/id_ex_stage_pkg.sv | 50 +++++
 rtl/id_ex_stage_operand_fwd_mux.sv | 13 +
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - miniRV writeback/ALU/branch codes and the ID/EX bubble control bundle
package id_ex_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_RAM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_PC4 = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  typedef struct packed {
    logic [4:0] wr;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic [3:0] alu_op;
    logic       alub_sel;
    logic       ram_we;
    logic [2:0] br_type;
  } ctrl_t;

  // A bubble must never write the regfile or memory, nor resolve a branch.
  localparam ctrl_t CTRL_BUBBLE = '{
    wr:       5'd0,
    rf_we:    1'b0,
    rf_wsel:  WB_ALU,
    alu_op:   ALU_ADD,
    alub_sel: 1'b0,
    ram_we:   1'b0,
    br_type:  BR_NONE
  };

endpackage

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// rtl/id_ex_stage_operand_fwd_mux.sv - selects forwarded vs regfile data for one operand
module operand_fwd_mux #(
  parameter int W = 32
) (
  input  logic         hazard_i,
  input  logic [W-1:0] fwd_data_i,
  input  logic [W-1:0] rf_data_i,
  output logic [W-1:0] data_o
);

  assign data_o = hazard_i ? fwd_data_i : rf_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - miniRV ID/EX pipeline register with bubble/flush/freeze and stall requests
// Optional event counters are built when ID_EX_PERF_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] NOP_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_pc4,
  input  logic [XLEN-1:0] id_imm_ext,
  input  logic [XLEN-1:0] id_rD1,
  input  logic [XLEN-1:0] id_rD2,
  input  logic            rs1_hazard,
  input  logic            rs2_hazard,
  input  logic [XLEN-1:0] rs1_forward_data,
  input  logic [XLEN-1:0] rs2_forward_data,
  input  logic            load_use_flag,
  input  logic [4:0]      id_wR,
  input  logic            id_rf_we,
  input  logic [1:0]      id_rf_wsel,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alub_sel,
  input  logic            id_ram_we,
  input  logic [2:0]      id_br_type,
  input  logic            ex_flush,
  input  logic            pipe_freeze,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_pc4,
  output logic [XLEN-1:0] id_ex_imm_ext,
  output logic [XLEN-1:0] id_ex_rD1,
  output logic [XLEN-1:0] id_ex_rD2,
  output logic [4:0]      id_ex_wR,
  output logic            id_ex_rf_we,
  output logic [1:0]      id_ex_rf_wsel,
  output logic [3:0]      id_ex_alu_op,
  output logic            id_ex_alub_sel,
  output logic            id_ex_ram_we,
  output logic [2:0]      id_ex_br_type,
`ifdef ID_EX_PERF_EN
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic            pc_stall,
  output logic            if_id_stall
);

  logic [XLEN-1:0] rd1_sel, rd2_sel;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, pc4_q, pc4_d, imm_q, imm_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  ctrl_t           ctrl_q, ctrl_d, ctrl_in;
  logic            flush_take, lu_bubble, make_bubble;

  operand_fwd_mux #(.W(XLEN)) u_fwd_rs1 (
    .hazard_i   (rs1_hazard),
    .fwd_data_i (rs1_forward_data),
    .rf_data_i  (id_rD1),
    .data_o     (rd1_sel)
  );

  operand_fwd_mux #(.W(XLEN)) u_fwd_rs2 (
    .hazard_i   (rs2_hazard),
    .fwd_data_i (rs2_forward_data),
    .rf_data_i  (id_rD2),
    .data_o     (rd2_sel)
  );

  // A flush squashes the dependent instruction, so it must not also hold the front end.
  assign pc_stall    = (load_use_flag & ~ex_flush) | pipe_freeze;
  assign if_id_stall = pc_stall;

  assign flush_take  = ex_flush & ~pipe_freeze;
  assign lu_bubble   = load_use_flag & ~ex_flush & ~pipe_freeze;
  assign make_bubble = flush_take | (~pipe_freeze & (load_use_flag | ~id_valid));

  assign ctrl_in = '{
    wr:       id_wR,
    rf_we:    id_rf_we,
    rf_wsel:  id_rf_wsel,
    alu_op:   id_alu_op,
    alub_sel: id_alub_sel,
    ram_we:   id_ram_we,
    br_type:  id_br_type
  };

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    imm_d   = imm_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    ctrl_d  = ctrl_q;
    if (make_bubble) begin
      valid_d = 1'b0;
      pc_d    = NOP_PC;
      pc4_d   = NOP_PC;
      imm_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (!pipe_freeze) begin
      valid_d = 1'b1;
      pc_d    = id_pc;
      pc4_d   = id_pc4;
      imm_d   = id_imm_ext;
      rd1_d   = rd1_sel;
      rd2_d   = rd2_sel;
      ctrl_d  = ctrl_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= NOP_PC;
      pc4_q   <= NOP_PC;
      imm_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      imm_q   <= imm_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (lu_bubble)  bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (flush_take) flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = lu_bubble;
`endif

  assign id_ex_valid    = valid_q;
  assign id_ex_pc       = pc_q;
  assign id_ex_pc4      = pc4_q;
  assign id_ex_imm_ext  = imm_q;
  assign id_ex_rD1      = rd1_q;
  assign id_ex_rD2      = rd2_q;
  assign id_ex_wR       = ctrl_q.wr;
  assign id_ex_rf_we    = ctrl_q.rf_we;
  assign id_ex_rf_wsel  = ctrl_q.rf_wsel;
  assign id_ex_alu_op   = ctrl_q.alu_op;
  assign id_ex_alub_sel = ctrl_q.alub_sel;
  assign id_ex_ram_we   = ctrl_q.ram_we;
  assign id_ex_br_type  = ctrl_q.br_type;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (directed vectors)
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  wr;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic [3:0]  alu_op;
    logic        alub_sel;
    logic        ram_we;
    logic [2:0]  br_type;
  } out_t;

  typedef struct packed {
    logic stall;
    logic perf_zero;
    out_t regs;
  } item_t;

  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_BUB  = 2'd1;
  localparam logic [1:0] K_HOLD = 2'd2;

  localparam out_t BUB = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, imm: 32'h0, rd1: 32'h0, rd2: 32'h0,
                           wr: 5'd0, rf_we: 1'b0, rf_wsel: 2'd0, alu_op: 4'd0, alub_sel: 1'b0,
                           ram_we: 1'b0, br_type: 3'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_imm_ext, id_rD1, id_rD2;
  logic        rs1_hazard, rs2_hazard;
  logic [31:0] rs1_forward_data, rs2_forward_data;
  logic        load_use_flag;
  logic [4:0]  id_wR;
  logic        id_rf_we;
  logic [1:0]  id_rf_wsel;
  logic [3:0]  id_alu_op;
  logic        id_alub_sel, id_ram_we;
  logic [2:0]  id_br_type;
  logic        ex_flush, pipe_freeze;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_pc4, id_ex_imm_ext, id_ex_rD1, id_ex_rD2;
  logic [4:0]  id_ex_wR;
  logic        id_ex_rf_we;
  logic [1:0]  id_ex_rf_wsel;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alub_sel, id_ex_ram_we;
  logic [2:0]  id_ex_br_type;
  logic        pc_stall, if_id_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

  int    n_vec  = 0;
  int    n_fail = 0;
  item_t sb[$];
  out_t  exp_state;
  logic  prev_rst;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_pc4           (id_pc4),
    .id_imm_ext       (id_imm_ext),
    .id_rD1           (id_rD1),
    .id_rD2           (id_rD2),
    .rs1_hazard       (rs1_hazard),
    .rs2_hazard       (rs2_hazard),
    .rs1_forward_data (rs1_forward_data),
    .rs2_forward_data (rs2_forward_data),
    .load_use_flag    (load_use_flag),
    .id_wR            (id_wR),
    .id_rf_we         (id_rf_we),
    .id_rf_wsel       (id_rf_wsel),
    .id_alu_op        (id_alu_op),
    .id_alub_sel      (id_alub_sel),
    .id_ram_we        (id_ram_we),
    .id_br_type       (id_br_type),
    .ex_flush         (ex_flush),
    .pipe_freeze      (pipe_freeze),
    .id_ex_valid      (id_ex_valid),
    .id_ex_pc         (id_ex_pc),
    .id_ex_pc4        (id_ex_pc4),
    .id_ex_imm_ext    (id_ex_imm_ext),
    .id_ex_rD1        (id_ex_rD1),
    .id_ex_rD2        (id_ex_rD2),
    .id_ex_wR         (id_ex_wR),
    .id_ex_rf_we      (id_ex_rf_we),
    .id_ex_rf_wsel    (id_ex_rf_wsel),
    .id_ex_alu_op     (id_ex_alu_op),
    .id_ex_alub_sel   (id_ex_alub_sel),
    .id_ex_ram_we     (id_ex_ram_we),
    .id_ex_br_type    (id_ex_br_type),
`ifdef ID_EX_PERF_EN
    .perf_bubble_cnt  (perf_bubble_cnt),
    .perf_flush_cnt   (perf_flush_cnt),
`endif
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall)
  );

  // Monitor: one expected item per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      out_t  act;
      it  = sb.pop_front();
      act = '{valid: id_ex_valid, pc: id_ex_pc, pc4: id_ex_pc4, imm: id_ex_imm_ext,
              rd1: id_ex_rD1, rd2: id_ex_rD2, wr: id_ex_wR, rf_we: id_ex_rf_we,
              rf_wsel: id_ex_rf_wsel, alu_op: id_ex_alu_op, alub_sel: id_ex_alub_sel,
              ram_we: id_ex_ram_we, br_type: id_ex_br_type};
      n_vec++;
      if ({pc_stall, if_id_stall} !== {2{it.stall}}) begin
        n_fail++;
        $display("FAIL stall t=%0t: got pc_stall=%b if_id_stall=%b, want %b", $time, pc_stall, if_id_stall, it.stall);
      end
      n_vec++;
      if (act !== it.regs) begin
        n_fail++;
        $display("FAIL regs t=%0t: got %h, want %h", $time, act, it.regs);
      end
`ifdef ID_EX_PERF_EN
      if (it.perf_zero) begin
        n_vec++;
        if ({perf_bubble_cnt, perf_flush_cnt} !== 64'h0) begin
          n_fail++;
          $display("FAIL perf_reset t=%0t: got bubble=%0d flush=%0d, want 0/0", $time, perf_bubble_cnt, perf_flush_cnt);
        end
      end
`endif
    end
  end

  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic h1, input logic h2,
                      input logic [31:0] f1, input logic [31:0] f2,
                      input logic lu, input logic fl, input logic fz,
                      input logic [1:0] kind, input logic [31:0] e1, input logic [31:0] e2,
                      input logic es);
    item_t it;
    rst = r; id_valid = v; id_pc = pc; id_pc4 = pc + 32'd4;
    id_imm_ext = pc ^ 32'hA5A5_0000;
    id_rD1 = rd1; id_rD2 = rd2; rs1_hazard = h1; rs2_hazard = h2;
    rs1_forward_data = f1; rs2_forward_data = f2;
    load_use_flag = lu; ex_flush = fl; pipe_freeze = fz;
    id_wR = pc[6:2]; id_rf_we = ~pc[2]; id_rf_wsel = pc[3:2]; id_alu_op = pc[5:2];
    id_alub_sel = pc[3]; id_ram_we = pc[4]; id_br_type = pc[6:4];
    it.stall = es; it.perf_zero = prev_rst; it.regs = exp_state;
    sb.push_back(it);
    case (kind)
      K_LOAD: exp_state = '{valid: 1'b1, pc: pc, pc4: pc + 32'd4, imm: pc ^ 32'hA5A5_0000,
                            rd1: e1, rd2: e2, wr: pc[6:2], rf_we: ~pc[2], rf_wsel: pc[3:2],
                            alu_op: pc[5:2], alub_sel: pc[3], ram_we: pc[4], br_type: pc[6:4]};
      K_BUB:  exp_state = BUB;
      default: ;
    endcase
    prev_rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_pc4 = '0; id_imm_ext = '0;
    id_rD1 = '0; id_rD2 = '0; rs1_hazard = 1'b0; rs2_hazard = 1'b0;
    rs1_forward_data = '0; rs2_forward_data = '0; load_use_flag = 1'b0;
    id_wR = '0; id_rf_we = 1'b0; id_rf_wsel = '0; id_alu_op = '0;
    id_alub_sel = 1'b0; id_ram_we = 1'b0; id_br_type = '0;
    ex_flush = 1'b0; pipe_freeze = 1'b0;
    exp_state = BUB; prev_rst = 1'b1;
    @(posedge clk);
    #1;
    //    rst  v    pc         rd1    rd2    h1   h2   f1        f2        lu   fl   fz   kind    e1        e2        stall
    step(1'b1,1'b1,32'h200, 32'h1, 32'h2, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_BUB, 32'h0,    32'h0,    1'b0);
    step(1'b0,1'b1,32'h100, 32'h11,32'h22,1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_LOAD,32'h11,   32'h22,   1'b0);
    step(1'b0,1'b1,32'h104, 32'h7, 32'h5, 1'b0,1'b1,32'h0,    32'hDEAD, 1'b0,1'b0,1'b0,K_LOAD,32'h7,    32'hDEAD, 1'b0);
    step(1'b0,1'b1,32'h108, 32'h1, 32'h2, 1'b1,1'b1,32'hBEEF, 32'hCAFE, 1'b0,1'b0,1'b0,K_LOAD,32'hBEEF, 32'hCAFE, 1'b0);
    step(1'b0,1'b1,32'h10C, 32'h33,32'h44,1'b0,1'b0,32'h0,    32'h0,    1'b1,1'b0,1'b0,K_BUB, 32'h0,    32'h0,    1'b1);
    step(1'b0,1'b1,32'h10C, 32'h33,32'h44,1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_LOAD,32'h33,   32'h44,   1'b0);
    step(1'b0,1'b0,32'h110, 32'h9, 32'h9, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_BUB, 32'h0,    32'h0,    1'b0);
    step(1'b0,1'b1,32'h114, 32'h9, 32'h9, 1'b0,1'b0,32'h0,    32'h0,    1'b1,1'b1,1'b0,K_BUB, 32'h0,    32'h0,    1'b0);
    step(1'b0,1'b1,32'h118, 32'h55,32'h66,1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_LOAD,32'h55,   32'h66,   1'b0);
    step(1'b0,1'b1,32'h11C, 32'hA, 32'hB, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b1,K_HOLD,32'h0,    32'h0,    1'b1);
    step(1'b0,1'b1,32'h120, 32'hC, 32'hD, 1'b1,1'b0,32'h77,   32'h0,    1'b0,1'b1,1'b1,K_HOLD,32'h0,    32'h0,    1'b1);
    step(1'b0,1'b0,32'h124, 32'hE, 32'hF, 1'b0,1'b0,32'h0,    32'h0,    1'b1,1'b0,1'b1,K_HOLD,32'h0,    32'h0,    1'b1);
    step(1'b0,1'b1,32'h128, 32'h88,32'h99,1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_LOAD,32'h88,   32'h99,   1'b0);
    step(1'b0,1'b1,32'h12C, 32'h1, 32'h1, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b1,K_HOLD,32'h0,    32'h0,    1'b1);
    step(1'b1,1'b1,32'h12C, 32'h1, 32'h1, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b1,K_BUB, 32'h0,    32'h0,    1'b1);
    step(1'b0,1'b1,32'h130, 32'h3, 32'h4, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_LOAD,32'h3,    32'h4,    1'b0);
    step(1'b0,1'b1,32'h134, 32'h5, 32'h6, 1'b0,1'b0,32'h0,    32'h0,    1'b1,1'b0,1'b0,K_BUB, 32'h0,    32'h0,    1'b1);
    step(1'b0,1'b1,32'h134, 32'h5, 32'h6, 1'b1,1'b0,32'h1234, 32'h0,    1'b0,1'b0,1'b0,K_LOAD,32'h1234, 32'h6,    1'b0);
    step(1'b0,1'b1,32'h138, 32'h7, 32'h8, 1'b0,1'b1,32'h0,    32'h4321, 1'b0,1'b0,1'b0,K_LOAD,32'h7,    32'h4321, 1'b0);
    step(1'b1,1'b1,32'h13C, 32'h7, 32'h8, 1'b0,1'b0,32'h0,    32'h0,    1'b1,1'b0,1'b0,K_BUB, 32'h0,    32'h0,    1'b1);
    step(1'b0,1'b0,32'h0,   32'h0, 32'h0, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_BUB, 32'h0,    32'h0,    1'b0);
    step(1'b0,1'b0,32'h0,   32'h0, 32'h0, 1'b0,1'b0,32'h0,    32'h0,    1'b0,1'b0,1'b0,K_BUB, 32'h0,    32'h0,    1'b0);
    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d items left in scoreboard, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
